// File: rtl/pcm_interpolator.sv
// Audio-rate PCM to fast-clock linear interpolator with input FIFO, feeding the delta-sigma DAC.
// Optional soft mute: define PCM_INTERP_SOFT_MUTE_EN to add the mute input.
module pcm_interpolator #(
   parameter int DATA_W     = 16,
   parameter int RATIO_LOG2 = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
`ifdef PCM_INTERP_SOFT_MUTE_EN
   input  logic                          mute,
`endif
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic signed [DATA_W-1:0]      s_data,
   output logic signed [DATA_W-1:0]      pcm_out,
   output logic                          sample_tick,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int PROD_W = DATA_W + 2 + RATIO_LOG2;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t                   state_q, state_d;
   logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [LVL_W-1:0]         level;
   logic [RATIO_LOG2-1:0]    phase_q;
   logic signed [DATA_W-1:0] prev_q, cur_q, head;
   logic                     full, empty, push, pop, seg_start, mute_i;
   logic                     tick_p0, und_p0;

`ifdef PCM_INTERP_SOFT_MUTE_EN
   assign mute_i = mute;
`else
   assign mute_i = 1'b0;
`endif

   // Floor-shifted linear interpolation; the result lies between a and b, so truncation is exact.
   function automatic logic signed [DATA_W-1:0] lerp(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input logic [RATIO_LOG2-1:0]    ph
   );
      logic signed [DATA_W:0]   diff;
      logic signed [PROD_W-1:0] d_ext, p_ext, a_ext, prod, sum;
      diff  = {b[DATA_W-1], b} - {a[DATA_W-1], a};
      d_ext = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
      p_ext = {{(PROD_W-RATIO_LOG2){1'b0}}, ph};
      a_ext = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
      prod  = d_ext * p_ext;
      sum   = (prod >>> RATIO_LOG2) + a_ext;
      return sum[DATA_W-1:0];
   endfunction

   assign full       = (level == LVL_W'(FIFO_DEPTH));
   assign empty      = (level == '0);
   assign s_ready    = !full;
   assign fifo_level = level;
   assign push       = s_valid && !full;
   assign head       = mem[rd_ptr];
   assign seg_start  = (state_q == IDLE) ? !empty : (&phase_q);
   assign pop        = seg_start && !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (!empty) state_d = RUN;
         RUN, HOLD: if (seg_start) state_d = empty ? HOLD : RUN;
         default:   state_d = IDLE;
      endcase
   end

   // Stage p0: segment bookkeeping (phase, endpoints, event flags)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         prev_q  <= '0;
         cur_q   <= '0;
         tick_p0 <= 1'b0;
         und_p0  <= 1'b0;
      end else begin
         phase_q <= (state_q == IDLE) ? '0 : phase_q + RATIO_LOG2'(1);
         tick_p0 <= seg_start;
         und_p0  <= seg_start && empty && (state_q != IDLE);
         if (seg_start) begin
            prev_q <= (state_q == IDLE) ? '0 : cur_q;
            if (mute_i)      cur_q <= '0;
            else if (!empty) cur_q <= head;
         end
      end
   end

   // Stage p1: registered output, events aligned with the first sample of each segment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcm_out     <= '0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         pcm_out     <= (state_q == IDLE) ? '0 : lerp(prev_q, cur_q, phase_q);
         sample_tick <= tick_p0;
         underrun    <= und_p0;
      end
   end

endmodule
